logic_gate_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-bit NOT gate.
- Applies one of eight bitwise gate operations, selected per transaction, to WIDTH-bit operands.
- Results are buffered in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
- Also keeps a saturating count of delivered results; sits between a stimulus source and any downstream consumer in the gate-exercise designs.

---
 rtl/logic_gate_pipe_if.sv | 24 ++
 rtl/logic_gate_pipe.sv | 112 +++++++++++
 tb/tb_logic_gate_pipe.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/logic_gate_pipe_if.sv
// Handshake bundle for logic_gate_pipe: operand/op input channel and result output channel.
interface logic_gate_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [2:0]       out_op;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_op
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_op
    );
endinterface

// File: rtl/logic_gate_pipe.sv
// Bitwise gate unit (8 selectable ops) feeding a DEPTH-entry result FIFO, with a
// saturating count of delivered results.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    logic_gate_pipe_if.slave        bus,
    input  logic                    clear_count,
    output logic [CNT_W-1:0]        xfer_count
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_BUF  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    OCC_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]    OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [WIDTH-1:0] gate_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_NOT:  r = ~a;
            OP_BUF:  r = a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    logic [WIDTH-1:0] y_mem  [DEPTH];
    logic [2:0]       op_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] res_p0;

    // Stage p0: combinational gate evaluation on the accepted operands
    assign res_p0 = gate_eval(bus.in_a, bus.in_b, bus.in_op);

    // in_ready depends only on occupancy, so a same-cycle pop never opens a full FIFO
    assign bus.in_ready  = !rst && (occ < OCC_FULL);
    assign bus.out_valid = (occ != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Stage p1: FIFO storage; data words carry no reset and are only written on accept
    always_ff @(posedge clk) begin
        if (push) begin
            y_mem[wr_ptr]  <= res_p0;
            op_mem[wr_ptr] <= bus.in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Head is gated by valid so stale or uninitialised words never reach the outputs
    assign bus.out_y  = bus.out_valid ? y_mem[rd_ptr]  : '0;
    assign bus.out_op = bus.out_valid ? op_mem[rd_ptr] : 3'd0;

    always_ff @(posedge clk) begin
        if (rst || clear_count) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= sat_inc(xfer_count);
        end
    end
endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomised and directed checks of logic_gate_pipe against a queue-based reference model.
module tb_logic_gate_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_count;
    logic [15:0] xfer16;
    logic [3:0]  xfer4;

    logic_gate_pipe_if #(.WIDTH(WIDTH)) bus ();
    logic_gate_pipe_if #(.WIDTH(WIDTH)) bus4 ();

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_a      = bus.in_a;
    assign bus4.in_b      = bus.in_b;
    assign bus4.in_op     = bus.in_op;
    assign bus4.out_ready = bus.out_ready;

    logic_gate_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .clear_count(clear_count), .xfer_count(xfer16)
    );

    logic_gate_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave),
        .clear_count(clear_count), .xfer_count(xfer4)
    );

    always #5 clk = ~clk;

    // Truth table per op, nibble index = op; bit index = {a,b}
    localparam logic [31:0] TT = {4'b1001, 4'b0110, 4'b0001, 4'b0111,
                                  4'b1110, 4'b1000, 4'b1100, 4'b0011};

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [2:0]       op;
    } ent_t;

    ent_t q[$];
    int   m16;
    int   m4;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [WIDTH-1:0] ref_gate(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [2:0] op);
        logic [WIDTH-1:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx  = int'(op) * 4 + (a[i] ? 2 : 0) + (b[i] ? 1 : 0);
            r[i] = TT[idx];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [WIDTH-1:0] ey;
        logic [2:0]       eop;
        ey  = (q.size() > 0) ? q[0].y  : '0;
        eop = (q.size() > 0) ? q[0].op : 3'd0;
        chk("in_ready",  32'(bus.in_ready),  32'(!rst && q.size() < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("out_y",     32'(bus.out_y),     32'(ey));
        chk("out_op",    32'(bus.out_op),    32'(eop));
        chk("out_y_c4",  32'(bus4.out_y),    32'(ey));
        chk("count16",   32'(xfer16),        32'(m16));
        chk("count4",    32'(xfer4),         32'(m4));
    endtask

    task automatic tick();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = !rst && bus.in_valid && (q.size() < DEPTH);
        do_pop  = !rst && bus.out_ready && (q.size() > 0);
        e.y     = ref_gate(bus.in_a, bus.in_b, bus.in_op);
        e.op    = bus.in_op;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m16 = 0;
            m4  = 0;
        end else begin
            if (do_pop) q.delete(0);
            if (do_push) q.push_back(e);
            if (clear_count) begin
                m16 = 0;
                m4  = 0;
            end else if (do_pop) begin
                if (m16 < 65535) m16++;
                if (m4 < 15) m4++;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic rdy);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.out_ready = rdy;
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        sweep_exp = '{8'h0F, 8'hF0, 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3};
        m16 = 0;
        m4  = 0;
        rst = 1'b1;
        clear_count = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();
        tick();
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Single NOT transaction
        drive(1'b1, 8'hA5, 8'($urandom), 3'd0, 1'b1);
        tick();
        chk("not_valid", 32'(bus.out_valid), 32'd1);
        chk("not_y", 32'(bus.out_y), 32'h5A);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        tick();
        chk("not_count", 32'(xfer16), 32'd1);

        // Op sweep, back-to-back
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 8'hF0, 8'hCC, 3'(k), 1'b1);
            tick();
            chk("sweep_y", 32'(bus.out_y), 32'(sweep_exp[k]));
            chk("sweep_op", 32'(bus.out_op), 32'(k));
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        tick();
        chk("sweep_count", 32'(xfer16), 32'd8);

        // Fill, stall, drain in order
        drive(1'b1, 8'h3C, 8'h0F, 3'd2, 1'b0);
        tick();
        drive(1'b1, 8'h3C, 8'h0F, 3'd3, 1'b0);
        tick();
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 8'h3C, 8'h0F, 3'd6, 1'b0);
        tick();
        chk("full_head", 32'(bus.out_y), 32'h0C);
        bus.out_ready = 1'b1;
        tick();
        chk("drain_b", 32'(bus.out_y), 32'h3F);
        chk("drain_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("drain_c", 32'(bus.out_y), 32'h33);
        bus.in_valid = 1'b0;
        tick();
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Reset with entries queued
        drive(1'b1, 8'h12, 8'h34, 3'd6, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(xfer16), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 8'h00, 8'h00, 3'd7, 1'b1);
        tick();
        chk("post_rst_y", 32'(bus.out_y), 32'hFF);
        bus.in_valid = 1'b0;
        tick();
        chk("post_rst_empty", 32'(bus.out_valid), 32'd0);

        // Counter saturation and clear priority
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("sat4", 32'(xfer4), 32'd15);
        chk("cnt16_17", 32'(xfer16), 32'd17);
        drive(1'b1, 8'h55, 8'hAA, 3'd6, 1'b0);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        clear_count   = 1'b1;
        tick();
        clear_count = 1'b0;
        chk("clr4", 32'(xfer4), 32'd0);
        chk("clr16", 32'(xfer16), 32'd0);

        // Randomised traffic with occasional clear and reset
        for (int n = 0; n < 600; n++) begin
            drive(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
                  ($urandom % 3) != 0);
            clear_count = (($urandom % 60) == 0);
            rst         = (($urandom % 150) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
